// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read channel, decode-side hand-off and redirect inputs.
interface fetch_unit_if;
  logic        Mem_Req;
  logic [31:0] Mem_Addr;
  logic        Mem_Ack;
  logic [31:0] Mem_Data;
  logic        Instr_Valid;
  logic        Instr_Ready;
  logic [31:0] Instr;
  logic [5:0]  Opcode;
  logic [4:0]  Rs;
  logic [4:0]  Rd;
  logic [4:0]  Rt;
  logic [15:0] Imm16;
  logic [31:0] PC;
  logic        PC_Sel;
  logic [31:0] Imm_Ext;
  logic        Flush;
  logic [31:0] Flush_Addr;

  modport master (
    output Mem_Req, Mem_Addr, Instr_Valid, Instr, Opcode, Rs, Rd, Rt, Imm16, PC,
    input  Mem_Ack, Mem_Data, Instr_Ready, PC_Sel, Imm_Ext, Flush, Flush_Addr
  );

  modport slave (
    input  Mem_Req, Mem_Addr, Instr_Valid, Instr, Opcode, Rs, Rd, Rt, Imm16, PC,
    output Mem_Ack, Mem_Data, Instr_Ready, PC_Sel, Imm_Ext, Flush, Flush_Addr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads, holds the returned instruction in IR until decode
// accepts it, and redirects on branch or flush (draining any read that cannot be cancelled).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          Clk,
  input logic          Reset,
  fetch_unit_if.master bus
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_ADDR = {RESET_PC[XLEN-1:2], 2'b00};

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_e;

  state_e          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;

  logic [XLEN-1:0] flush_tgt;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] drain_tgt;

  // Redirect targets are word aligned; arithmetic wraps naturally at 32 bits.
  assign flush_tgt = {bus.Flush_Addr[XLEN-1:2], 2'b00};
  assign seq_pc    = pc_q + XLEN'(4);
  assign br_pc     = bus.PC_Sel ? (seq_pc + bus.Imm_Ext) : seq_pc;
  assign next_pc   = {br_pc[XLEN-1:2], 2'b00};
  assign drain_tgt = bus.Flush ? flush_tgt : pend_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_ADDR;
      valid_q    <= 1'b0;
      ir_q       <= '0;
      pc_q       <= RESET_ADDR;
      pend_q     <= RESET_ADDR;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    valid_d    = valid_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    pend_d     = pend_q;

    case (state_q)
      IDLE: begin
        state_d   = FETCH;
        mem_req_d = 1'b1;
        if (bus.Flush) mem_addr_d = flush_tgt;
      end
      FETCH: begin
        if (bus.Mem_Ack) begin
          if (bus.Flush) begin
            mem_addr_d = flush_tgt;
          end else begin
            ir_d      = bus.Mem_Data;
            pc_d      = mem_addr_q;
            valid_d   = 1'b1;
            mem_req_d = 1'b0;
            state_d   = HOLD;
          end
        end else if (bus.Flush) begin
          // Outstanding read cannot be withdrawn; remember where to go once it lands.
          pend_d  = flush_tgt;
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (bus.Flush) begin
          valid_d    = 1'b0;
          mem_addr_d = flush_tgt;
          mem_req_d  = 1'b1;
          state_d    = FETCH;
        end else if (bus.Instr_Ready) begin
          valid_d    = 1'b0;
          mem_addr_d = next_pc;
          mem_req_d  = 1'b1;
          state_d    = FETCH;
        end
      end
      DRAIN: begin
        if (bus.Flush) pend_d = flush_tgt;
        if (bus.Mem_Ack) begin
          mem_addr_d = drain_tgt;
          state_d    = FETCH;
        end
      end
    endcase
  end

  assign bus.Mem_Req     = mem_req_q;
  assign bus.Mem_Addr    = mem_addr_q;
  assign bus.Instr_Valid = valid_q;
  assign bus.Instr       = ir_q;
  assign bus.PC          = pc_q;
  assign bus.Opcode      = ir_q[31:26];
  assign bus.Rs          = ir_q[25:21];
  assign bus.Rd          = ir_q[20:16];
  assign bus.Rt          = ir_q[15:11];
  assign bus.Imm16       = ir_q[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a
// transaction-level model of the fetch/hold/redirect behaviour.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Model: what the fetch stage should be showing, in transaction terms.
  bit          m_idle;
  bit          m_req;
  bit          m_valid;
  bit          m_drop;
  logic [31:0] m_addr;
  logic [31:0] m_ir;
  logic [31:0] m_pc;
  logic [31:0] m_tgt;

  task automatic model_reset();
    m_idle  = 1'b1;
    m_req   = 1'b0;
    m_valid = 1'b0;
    m_drop  = 1'b0;
    m_addr  = RST_PC & 32'hFFFF_FFFC;
    m_pc    = RST_PC & 32'hFFFF_FFFC;
    m_ir    = 32'h0;
    m_tgt   = 32'h0;
  endtask

  task automatic model_step(input bit ack, input logic [31:0] data, input bit flush,
                            input logic [31:0] fa, input bit rdy, input bit sel,
                            input logic [31:0] imm);
    logic [31:0] fa_w;
    fa_w = fa & 32'hFFFF_FFFC;
    if (m_idle) begin
      m_idle = 1'b0;
      m_req  = 1'b1;
      if (flush) m_addr = fa_w;
    end else if (m_valid) begin
      if (flush) begin
        m_valid = 1'b0; m_req = 1'b1; m_addr = fa_w;
      end else if (rdy) begin
        m_valid = 1'b0; m_req = 1'b1;
        m_addr  = (m_pc + 32'd4 + (sel ? imm : 32'd0)) & 32'hFFFF_FFFC;
      end
    end else if (m_drop) begin
      if (flush) m_tgt = fa_w;
      if (ack) begin
        m_drop = 1'b0; m_addr = m_tgt;
      end
    end else if (ack) begin
      if (flush) m_addr = fa_w;
      else begin
        m_valid = 1'b1; m_ir = data; m_pc = m_addr; m_req = 1'b0;
      end
    end else if (flush) begin
      m_drop = 1'b1; m_tgt = fa_w;
    end
  endtask

  // Drive one cycle of inputs at the falling edge, let one rising edge pass, return at the next fall.
  task automatic cyc(input bit ack, input logic [31:0] data, input bit flush,
                     input logic [31:0] fa, input bit rdy, input bit sel, input logic [31:0] imm);
    bus.Mem_Ack     = ack;
    bus.Mem_Data    = data;
    bus.Flush       = flush;
    bus.Flush_Addr  = fa;
    bus.Instr_Ready = rdy;
    bus.PC_Sel      = sel;
    bus.Imm_Ext     = imm;
    if (!Reset) model_step(ack, data, flush, fa, rdy, sel, imm);
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    model_reset();
    bus.Mem_Ack = 1'b0; bus.Mem_Data = 32'h0; bus.Flush = 1'b0; bus.Flush_Addr = 32'h0;
    bus.Instr_Ready = 1'b0; bus.PC_Sel = 1'b0; bus.Imm_Ext = 32'h0;
    #1;
    checks++; if (bus.Mem_Req !== 1'b0) begin errors++; $display("FAIL rst_req_async got %0b want 0", bus.Mem_Req); end
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checks++; if (bus.Mem_Req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b want 0", bus.Mem_Req); end
    checks++; if (bus.Mem_Addr !== RST_PC) begin errors++; $display("FAIL rst_addr got %h want %h", bus.Mem_Addr, RST_PC); end
    checks++; if (bus.PC !== RST_PC) begin errors++; $display("FAIL rst_pc got %h want %h", bus.PC, RST_PC); end
    checks++; if (bus.Instr !== 32'h0) begin errors++; $display("FAIL rst_ir got %h want 0", bus.Instr); end
    checks++; if (bus.Instr_Valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", bus.Instr_Valid); end
    Reset = 1'b0;
  endtask

  task automatic test_fetch_latency();
    // IDLE cycle: no request yet, then request to RESET_PC.
    checks++; if (bus.Mem_Req !== 1'b0) begin errors++; $display("FAIL idle_req got %0b want 0", bus.Mem_Req); end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.Mem_Req !== 1'b1) begin errors++; $display("FAIL lat_req[%0d] got %0b want 1", i, bus.Mem_Req); end
      checks++; if (bus.Mem_Addr !== 32'h0) begin errors++; $display("FAIL lat_addr[%0d] got %h want 0", i, bus.Mem_Addr); end
      checks++; if (bus.Instr_Valid !== 1'b0) begin errors++; $display("FAIL lat_valid[%0d] got %0b want 0", i, bus.Instr_Valid); end
      cyc(i == 2, 32'h2000_0010, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    end
    checks++; if (bus.Instr_Valid !== 1'b1) begin errors++; $display("FAIL lat_valid_done got %0b want 1", bus.Instr_Valid); end
    checks++; if (bus.Opcode !== 6'h08) begin errors++; $display("FAIL lat_opcode got %h want 08", bus.Opcode); end
    checks++; if (bus.Imm16 !== 16'h0010) begin errors++; $display("FAIL lat_imm16 got %h want 0010", bus.Imm16); end
    checks++; if (bus.PC !== 32'h0) begin errors++; $display("FAIL lat_pc got %h want 0", bus.PC); end
    checks++; if (bus.Mem_Req !== 1'b0) begin errors++; $display("FAIL lat_req_done got %0b want 0", bus.Mem_Req); end
  endtask

  task automatic test_hold();
    // Stray acks while not requesting must be ignored.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 32'hBAD0_0000 + 32'(i), 1'b0, 32'h0, 1'b0, 1'b1, 32'h10);
      checks++; if (bus.Instr_Valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %0b want 1", i, bus.Instr_Valid); end
      checks++; if (bus.Instr !== 32'h2000_0010) begin errors++; $display("FAIL hold_ir[%0d] got %h want 20000010", i, bus.Instr); end
      checks++; if (bus.PC !== 32'h0) begin errors++; $display("FAIL hold_pc[%0d] got %h want 0", i, bus.PC); end
      checks++; if (bus.Mem_Req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d] got %0b want 0", i, bus.Mem_Req); end
    end
  endtask

  task automatic test_branch();
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0040);
    checks++; if (bus.Mem_Addr !== 32'h0000_0044) begin errors++; $display("FAIL br_addr got %h want 00000044", bus.Mem_Addr); end
    checks++; if (bus.Mem_Req !== 1'b1) begin errors++; $display("FAIL br_req got %0b want 1", bus.Mem_Req); end
    checks++; if (bus.Instr_Valid !== 1'b0) begin errors++; $display("FAIL br_valid got %0b want 0", bus.Instr_Valid); end
  endtask

  task automatic test_wrap();
    cyc(1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.PC !== 32'h0000_0044) begin errors++; $display("FAIL wr_pc44 got %h want 00000044", bus.PC); end
    // Flush beats Ready; low address bits are dropped.
    cyc(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h100);
    checks++; if (bus.Mem_Addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_flush_addr got %h want fffffffc", bus.Mem_Addr); end
    checks++; if (bus.Instr_Valid !== 1'b0) begin errors++; $display("FAIL wr_flush_valid got %0b want 0", bus.Instr_Valid); end
    cyc(1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_pc got %h want fffffffc", bus.PC); end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100);
    checks++; if (bus.Mem_Addr !== 32'h0000_0000) begin errors++; $display("FAIL wr_addr got %h want 00000000", bus.Mem_Addr); end
    checks++; if (bus.Mem_Req !== 1'b1) begin errors++; $display("FAIL wr_req got %0b want 1", bus.Mem_Req); end
  endtask

  task automatic test_flush_drain();
    cyc(1'b0, 32'h0, 1'b1, 32'h0000_0103, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.Mem_Addr !== 32'h0) begin errors++; $display("FAIL dr_addr[%0d] got %h want 0", i, bus.Mem_Addr); end
      checks++; if (bus.Mem_Req !== 1'b1) begin errors++; $display("FAIL dr_req[%0d] got %0b want 1", i, bus.Mem_Req); end
      cyc(i == 1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    end
    checks++; if (bus.Mem_Addr !== 32'h0000_0100) begin errors++; $display("FAIL dr_redirect got %h want 00000100", bus.Mem_Addr); end
    checks++; if (bus.Instr_Valid !== 1'b0) begin errors++; $display("FAIL dr_valid got %0b want 0", bus.Instr_Valid); end
    checks++; if (bus.Instr !== 32'hCAFE_F00D) begin errors++; $display("FAIL dr_ir got %h want cafef00d", bus.Instr); end
    // Last flush wins when it coincides with the draining ack.
    cyc(1'b0, 32'h0, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 32'h1111_1111, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.Mem_Addr !== 32'h0000_0300) begin errors++; $display("FAIL dr_last got %h want 00000300", bus.Mem_Addr); end
    // Flush together with ack while fetching discards the data.
    cyc(1'b1, 32'h2222_2222, 1'b1, 32'h0000_0400, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.Mem_Addr !== 32'h0000_0400) begin errors++; $display("FAIL fa_addr got %h want 00000400", bus.Mem_Addr); end
    checks++; if (bus.Instr_Valid !== 1'b0) begin errors++; $display("FAIL fa_valid got %0b want 0", bus.Instr_Valid); end
    checks++; if (bus.Mem_Req !== 1'b1) begin errors++; $display("FAIL fa_req got %0b want 1", bus.Mem_Req); end
  endtask

  task automatic test_reset_fetch();
    #2 Reset = 1'b1;
    model_reset();
    #1;
    checks++; if (bus.Mem_Req !== 1'b0) begin errors++; $display("FAIL rf_req_async got %0b want 0", bus.Mem_Req); end
    checks++; if (bus.Mem_Addr !== RST_PC) begin errors++; $display("FAIL rf_addr_async got %h want %h", bus.Mem_Addr, RST_PC); end
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    cyc(1'b1, 32'h3333_3333, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.Mem_Req !== 1'b1) begin errors++; $display("FAIL rf_req got %0b want 1", bus.Mem_Req); end
    checks++; if (bus.Mem_Addr !== RST_PC) begin errors++; $display("FAIL rf_addr got %h want %h", bus.Mem_Addr, RST_PC); end
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.Instr_Valid !== 1'b0) begin errors++; $display("FAIL rf_valid got %0b want 0", bus.Instr_Valid); end
    checks++; if (bus.Mem_Req !== 1'b1) begin errors++; $display("FAIL rf_req2 got %0b want 1", bus.Mem_Req); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 15) == 0, $urandom,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
      checks++; if (bus.Mem_Req !== m_req) begin errors++; $display("FAIL rnd_req@%0d got %0b want %0b", n, bus.Mem_Req, m_req); end
      checks++; if (bus.Mem_Addr !== m_addr) begin errors++; $display("FAIL rnd_addr@%0d got %h want %h", n, bus.Mem_Addr, m_addr); end
      checks++; if (bus.Instr_Valid !== m_valid) begin errors++; $display("FAIL rnd_valid@%0d got %0b want %0b", n, bus.Instr_Valid, m_valid); end
      checks++; if (bus.Instr !== m_ir) begin errors++; $display("FAIL rnd_ir@%0d got %h want %h", n, bus.Instr, m_ir); end
      checks++; if (bus.PC !== m_pc) begin errors++; $display("FAIL rnd_pc@%0d got %h want %h", n, bus.PC, m_pc); end
      checks++; if (bus.Opcode !== m_ir[31:26]) begin errors++; $display("FAIL rnd_op@%0d got %h want %h", n, bus.Opcode, m_ir[31:26]); end
      checks++; if ({bus.Rs, bus.Rd, bus.Rt} !== m_ir[25:11]) begin errors++; $display("FAIL rnd_regs@%0d got %h want %h", n, {bus.Rs, bus.Rd, bus.Rt}, m_ir[25:11]); end
      checks++; if (bus.Imm16 !== m_ir[15:0]) begin errors++; $display("FAIL rnd_imm@%0d got %h want %h", n, bus.Imm16, m_ir[15:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_latency();
    test_hold();
    test_branch();
    test_wrap();
    test_flush_drain();
    test_reset_fetch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
